// File: rtl/hamming_decoder_pipe.sv
// rtl/hamming_decoder_pipe.sv - dual independent two-stage Hamming SECDED decoder pipelines with error counters

module hamming_decoder_lane #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_BITS  = $clog2(DATA_BITS) + 1,
    parameter int ENCODED_WORD = DATA_BITS + PARITY_BITS,
    parameter int CNT_W        = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    input  logic [ENCODED_WORD+1:1] i_code,
    output logic                    o_ready,
    output logic                    o_valid,
    output logic [DATA_BITS-1:0]    o_data,
    output logic                    o_sec,
    output logic                    o_ded,
    input  logic                    i_ready,
    input  logic                    i_clr_cnt,
    output logic [CNT_W-1:0]        o_sec_cnt,
    output logic [CNT_W-1:0]        o_ded_cnt
);
    // Syndrome must be able to address every position 1..ENCODED_WORD.
    localparam int SYN_W = PARITY_BITS;

    logic                    en;
    logic [SYN_W-1:0]        syn_in;
    logic                    p_in;
    logic                    s1_valid;
    logic [ENCODED_WORD+1:1] s1_code;
    logic [SYN_W-1:0]        s1_syn;
    logic                    s1_p;
    logic [ENCODED_WORD+1:1] fixed;
    logic [DATA_BITS-1:0]    dec_data;
    logic                    dec_sec;
    logic                    dec_ded;

    // One enable advances the whole lane; it stalls only when the output is held.
    assign en      = !o_valid || i_ready;
    assign o_ready = en;

    // Syndrome is the XOR of the positions of all set bits; p is the overall parity check.
    always_comb begin
        syn_in = '0;
        for (int pos = 1; pos <= ENCODED_WORD; pos++) begin
            if (i_code[pos]) begin
                syn_in = syn_in ^ SYN_W'(pos);
            end
        end
        p_in = ^i_code;
    end

    // Stage 1: capture codeword with its syndrome and parity check.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_p     <= 1'b0;
        end else if (en) begin
            s1_valid <= i_valid;
            s1_code  <= i_code;
            s1_syn   <= syn_in;
            s1_p     <= p_in;
        end
    end

    // Classify the error, flip the addressed bit when correctable, then pull data from non-power-of-2 positions.
    always_comb begin
        fixed    = s1_code;
        dec_sec  = 1'b0;
        dec_ded  = 1'b0;
        dec_data = '0;
        if (s1_syn == '0) begin
            dec_sec = s1_p;
        end else if (!s1_p) begin
            dec_ded = 1'b1;
        end else if (s1_syn <= SYN_W'(ENCODED_WORD)) begin
            dec_sec = 1'b1;
            for (int pos = 1; pos <= ENCODED_WORD; pos++) begin
                if (SYN_W'(pos) == s1_syn) begin
                    fixed[pos] = ~fixed[pos];
                end
            end
        end else begin
            dec_ded = 1'b1;
        end
        // Shift in from the top so the lowest data position ends up in bit 0.
        for (int pos = 1; pos <= ENCODED_WORD; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                dec_data = {fixed[pos], dec_data[DATA_BITS-1:1]};
            end
        end
    end

    // Stage 2: result register; an empty slot loads zeroed data and flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sec   <= 1'b0;
            o_ded   <= 1'b0;
        end else if (en) begin
            o_valid <= s1_valid;
            o_data  <= s1_valid ? dec_data : '0;
            o_sec   <= s1_valid && dec_sec;
            o_ded   <= s1_valid && dec_ded;
        end
    end

    // Saturating event counters bumped on output handshake; clear takes priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sec_cnt <= '0;
            o_ded_cnt <= '0;
        end else if (i_clr_cnt) begin
            o_sec_cnt <= '0;
            o_ded_cnt <= '0;
        end else begin
            if (o_valid && i_ready && o_sec && (o_sec_cnt != '1)) begin
                o_sec_cnt <= o_sec_cnt + CNT_W'(1);
            end
            if (o_valid && i_ready && o_ded && (o_ded_cnt != '1)) begin
                o_ded_cnt <= o_ded_cnt + CNT_W'(1);
            end
        end
    end

endmodule

module hamming_decoder_pipe #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_BITS  = $clog2(DATA_BITS) + 1,
    parameter int ENCODED_WORD = DATA_BITS + PARITY_BITS,
    parameter int CNT_W        = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid_a,
    input  logic [ENCODED_WORD+1:1] i_code_a,
    output logic                    o_ready_a,
    output logic                    o_valid_a,
    output logic [DATA_BITS-1:0]    o_data_a,
    output logic                    o_sec_a,
    output logic                    o_ded_a,
    input  logic                    i_ready_a,
    input  logic                    i_valid_b,
    input  logic [ENCODED_WORD+1:1] i_code_b,
    output logic                    o_ready_b,
    output logic                    o_valid_b,
    output logic [DATA_BITS-1:0]    o_data_b,
    output logic                    o_sec_b,
    output logic                    o_ded_b,
    input  logic                    i_ready_b,
    input  logic                    i_clr_cnt,
    output logic [CNT_W-1:0]        o_sec_cnt_a,
    output logic [CNT_W-1:0]        o_ded_cnt_a,
    output logic [CNT_W-1:0]        o_sec_cnt_b,
    output logic [CNT_W-1:0]        o_ded_cnt_b
);

    hamming_decoder_lane #(
        .DATA_BITS    (DATA_BITS),
        .PARITY_BITS  (PARITY_BITS),
        .ENCODED_WORD (ENCODED_WORD),
        .CNT_W        (CNT_W)
    ) u_lane_a (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid_a),
        .i_code    (i_code_a),
        .o_ready   (o_ready_a),
        .o_valid   (o_valid_a),
        .o_data    (o_data_a),
        .o_sec     (o_sec_a),
        .o_ded     (o_ded_a),
        .i_ready   (i_ready_a),
        .i_clr_cnt (i_clr_cnt),
        .o_sec_cnt (o_sec_cnt_a),
        .o_ded_cnt (o_ded_cnt_a)
    );

    hamming_decoder_lane #(
        .DATA_BITS    (DATA_BITS),
        .PARITY_BITS  (PARITY_BITS),
        .ENCODED_WORD (ENCODED_WORD),
        .CNT_W        (CNT_W)
    ) u_lane_b (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid_b),
        .i_code    (i_code_b),
        .o_ready   (o_ready_b),
        .o_valid   (o_valid_b),
        .o_data    (o_data_b),
        .o_sec     (o_sec_b),
        .o_ded     (o_ded_b),
        .i_ready   (i_ready_b),
        .i_clr_cnt (i_clr_cnt),
        .o_sec_cnt (o_sec_cnt_b),
        .o_ded_cnt (o_ded_cnt_b)
    );

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// tb/tb_hamming_decoder_pipe.sv - directed self-checking bench for hamming_decoder_pipe

module tb_hamming_decoder_pipe;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid_a, i_valid_b;
    logic [13:1] i_code_a, i_code_b;
    logic        o_ready_a, o_ready_b;
    logic        o_valid_a, o_valid_b;
    logic [7:0]  o_data_a, o_data_b;
    logic        o_sec_a, o_sec_b, o_ded_a, o_ded_b;
    logic        i_ready_a, i_ready_b;
    logic        i_clr_cnt;
    logic [15:0] o_sec_cnt_a, o_ded_cnt_a, o_sec_cnt_b, o_ded_cnt_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_a_en = 1'b1;
    bit          mon_b_en = 1'b1;
    logic [9:0]  exp_a[$];
    logic [9:0]  exp_b[$];

    hamming_decoder_pipe dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid_a   (i_valid_a),
        .i_code_a    (i_code_a),
        .o_ready_a   (o_ready_a),
        .o_valid_a   (o_valid_a),
        .o_data_a    (o_data_a),
        .o_sec_a     (o_sec_a),
        .o_ded_a     (o_ded_a),
        .i_ready_a   (i_ready_a),
        .i_valid_b   (i_valid_b),
        .i_code_b    (i_code_b),
        .o_ready_b   (o_ready_b),
        .o_valid_b   (o_valid_b),
        .o_data_b    (o_data_b),
        .o_sec_b     (o_sec_b),
        .o_ded_b     (o_ded_b),
        .i_ready_b   (i_ready_b),
        .i_clr_cnt   (i_clr_cnt),
        .o_sec_cnt_a (o_sec_cnt_a),
        .o_ded_cnt_a (o_ded_cnt_a),
        .o_sec_cnt_b (o_sec_cnt_b),
        .o_ded_cnt_b (o_ded_cnt_b)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every output handshake must match the oldest expected result.
    always @(negedge i_clk) begin
        if (mon_a_en && o_valid_a && i_ready_a) begin
            if (exp_a.size() == 0) check("a_extra", 1, 0);
            else check("a_out", {o_data_a, o_sec_a, o_ded_a}, exp_a.pop_front());
        end
        if (mon_b_en && o_valid_b && i_ready_b) begin
            if (exp_b.size() == 0) check("b_extra", 1, 0);
            else check("b_out", {o_data_b, o_sec_b, o_ded_b}, exp_b.pop_front());
        end
    end

    // Present one codeword, wait for o_ready, record its expected {data, sec, ded}.
    task automatic send(input bit pb, input logic [13:1] c, input logic [9:0] e);
        int n = 0;
        if (pb) begin i_valid_b = 1'b1; i_code_b = c; end
        else    begin i_valid_a = 1'b1; i_code_a = c; end
        @(negedge i_clk);
        while (!(pb ? o_ready_b : o_ready_a) && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 50) check(pb ? "b_send_timeout" : "a_send_timeout", 0, 1);
        if (pb) exp_b.push_back(e); else exp_a.push_back(e);
        @(posedge i_clk);
        #1;
        if (pb) i_valid_b = 1'b0; else i_valid_a = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", 0, 1);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_valid_a = 1'b0; i_valid_b = 1'b0;
        i_code_a = '0; i_code_b = '0; i_ready_a = 1'b1; i_ready_b = 1'b1; i_clr_cnt = 1'b0;
        #1;
        check("rst_valid_a", o_valid_a, 0);
        check("rst_ready_a", o_ready_a, 1);
        check("rst_ready_b", o_ready_b, 1);
        check("rst_data_a", o_data_a, 0);
        check("rst_cnt_a", {o_sec_cnt_a, o_ded_cnt_a}, 0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Single words on port a, one at a time
        send(0, 13'h0A27, {8'hA5, 2'b00}); drain();
        check("clean_cnts", {o_sec_cnt_a, o_ded_cnt_a}, 0);
        send(0, 13'h0A07, {8'hA5, 2'b10}); drain();
        check("sec_cnt_1", o_sec_cnt_a, 1);
        send(0, 13'h1A27, {8'hA5, 2'b10}); drain();
        check("sec_cnt_2", o_sec_cnt_a, 2);
        send(0, 13'h0823, {8'h84, 2'b01}); drain();
        check("ded_cnt_1", o_ded_cnt_a, 1);
        check("sec_cnt_hold", o_sec_cnt_a, 2);
        send(0, 13'h0AAE, {8'hA5, 2'b01}); drain();
        check("ded_cnt_2", o_ded_cnt_a, 2);

        // Backpressure on a mid-stream while port b streams freely
        fork
            begin
                send(0, 13'h0F77, {8'hFF, 2'b00});
                send(0, 13'h0777, {8'hFF, 2'b10});
                send(0, 13'h0000, {8'h00, 2'b00});
                send(0, 13'h0001, {8'h00, 2'b10});
            end
            begin
                send(1, 13'h0A27, {8'hA5, 2'b00});
                send(1, 13'h0823, {8'h84, 2'b01});
                send(1, 13'h0F77, {8'hFF, 2'b00});
                send(1, 13'h0A07, {8'hA5, 2'b10});
            end
            begin
                repeat (3) @(posedge i_clk);
                #1 i_ready_a = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge i_clk);
                    check("bp_ready_low", o_ready_a, 0);
                    check("bp_valid_held", o_valid_a, 1);
                end
                @(posedge i_clk);
                #1 i_ready_a = 1'b1;
            end
        join
        drain();
        check("bp_cnt_a", {o_sec_cnt_a, o_ded_cnt_a}, {16'd4, 16'd2});
        check("bp_cnt_b", {o_sec_cnt_b, o_ded_cnt_b}, {16'd1, 16'd1});

        // Saturate port b sec counter
        mon_b_en = 1'b0;
        i_code_b = 13'h0A07;
        i_valid_b = 1'b1;
        repeat (65540) @(posedge i_clk);
        #1 i_valid_b = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        check("sat_sec_b", o_sec_cnt_b, 16'hFFFF);
        check("sat_ded_b", o_ded_cnt_b, 1);
        mon_b_en = 1'b1;

        // Clear coincident with an error handshake on a
        send(0, 13'h0A07, {8'hA5, 2'b10});
        @(negedge i_clk);
        @(negedge i_clk);
        check("clr_hs_pending", {o_valid_a, o_sec_a}, 2'b11);
        i_clr_cnt = 1'b1;
        @(posedge i_clk);
        #1 i_clr_cnt = 1'b0;
        check("clr_sec_a", o_sec_cnt_a, 0);
        check("clr_sec_b", o_sec_cnt_b, 0);
        check("clr_ded", {o_ded_cnt_a, o_ded_cnt_b}, 0);

        // Reset with two words in flight
        send(0, 13'h0F77, {8'hFF, 2'b00});
        send(0, 13'h0001, {8'h00, 2'b10});
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", o_valid_a, 0);
        check("mid_rst_ready", o_ready_a, 1);
        check("mid_rst_data", {o_data_a, o_sec_a, o_ded_a}, 0);
        exp_a.delete();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (6) @(negedge i_clk);
        check("post_rst_empty", o_valid_a, 0);

        // First word after reset: 2-cycle latency
        @(posedge i_clk); #1;
        send(0, 13'h0A07, {8'hA5, 2'b10});
        @(negedge i_clk);
        check("lat_cycle1", o_valid_a, 0);
        @(negedge i_clk);
        check("lat_cycle2", o_valid_a, 1);
        drain();
        check("post_rst_sec", o_sec_cnt_a, 1);
        check("post_rst_q", exp_a.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
